// File: rtl/hls_fifo_pkg.sv
// Shared sizing helpers and occupancy classification for the SRL stream FIFO.
package hls_fifo_pkg;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2
  } occ_state_e;

  // Ceiling log2, never below 1 so a 1-entry range still gets a real bit.
  function automatic int unsigned clog2_safe(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = (n > 0) ? n - 1 : 0;
    while (v != 0) begin
      r++;
      v = v >> 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

  function automatic int unsigned fifo_capacity(input int unsigned depth,
                                                input int unsigned output_reg);
    return depth + ((output_reg != 0) ? 1 : 0);
  endfunction

  function automatic int unsigned count_width(input int unsigned capacity);
    return clog2_safe(capacity + 1);
  endfunction

  function automatic occ_state_e occ_of(input int unsigned cnt, input int unsigned capacity);
    if (cnt == 0) return EMPTY;
    if (cnt >= capacity) return FULL;
    return PARTIAL;
  endfunction

endpackage

// File: rtl/hls_srl_fifo_shiftreg.sv
// Unreset shift-register storage: write shifts din into entry 0, read is an addressed tap.
module hls_srl_fifo_shiftreg
  import hls_fifo_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = 8,
  parameter  int unsigned DEPTH      = 16,
  localparam int unsigned AW         = clog2_safe(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         addr,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[0] <= din;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        mem[i] <= mem[i-1];
      end
    end
  end

  assign dout = mem[addr];

endmodule

// File: rtl/hls_srl_fifo_param.sv
// Parametrised SRL FIFO with occupancy count, almost-full flag and optional output register.
module hls_srl_fifo_param
  import hls_fifo_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = 8,
  parameter  int unsigned DEPTH      = 16,
  parameter  int unsigned AF_THRESH  = 12,
  parameter  int unsigned OUTPUT_REG = 0,
  localparam int unsigned CAPACITY   = fifo_capacity(DEPTH, OUTPUT_REG),
  localparam int unsigned CW         = count_width(CAPACITY)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_full_n,
  output logic                  if_almost_full_n,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic                  if_empty_n,
  output logic [CW-1:0]         count
);

  localparam int unsigned AW = clog2_safe(DEPTH);

  logic [CW-1:0]         count_q;
  logic [CW-1:0]         count_next;
  occ_state_e            occ_next;
  logic                  full_n_q;
  logic                  af_n_q;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  head_valid;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  srl_we;
  logic [AW-1:0]         srl_addr;
  logic [DATA_WIDTH-1:0] srl_dout;

  // Flags come only from registered state, so a same-cycle read never frees a full slot.
  assign wr_acc = if_write & full_n_q;
  assign rd_acc = if_read & head_valid;

  always_comb begin
    count_next = count_q;
    if (wr_acc && !rd_acc) begin
      count_next = count_q + CW'(1);
    end else if (rd_acc && !wr_acc) begin
      count_next = count_q - CW'(1);
    end
    occ_next = occ_of(32'(count_next), CAPACITY);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q  <= '0;
      full_n_q <= 1'b1;
      af_n_q   <= 1'b1;
    end else begin
      count_q  <= count_next;
      full_n_q <= (occ_next != FULL);
      af_n_q   <= (32'(count_next) < AF_THRESH);
    end
  end

  hls_srl_fifo_shiftreg #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) u_srl (
    .clk (clk),
    .we  (srl_we),
    .addr(srl_addr),
    .din (if_din),
    .dout(srl_dout)
  );

  assign srl_we = wr_acc;

  if (OUTPUT_REG == 0) begin : g_direct
    logic empty_n_q;

    // Oldest entry sits at count-1; a concurrent shift moves the next-oldest into that slot.
    assign srl_addr = AW'(count_q - CW'(1));

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        empty_n_q <= 1'b0;
      end else begin
        empty_n_q <= (count_next != '0);
      end
    end

    assign head_valid = empty_n_q;
    assign head_data  = srl_dout;
  end else begin : g_oreg
    logic [CW-1:0]         srl_cnt_q;
    logic [CW-1:0]         srl_cnt_next;
    logic                  out_valid_q;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic                  load;

    assign srl_addr = AW'(srl_cnt_q - CW'(1));

    // Refill the output stage whenever it is empty or being consumed and the SRL holds a word.
    always_comb begin
      load         = (!out_valid_q || rd_acc) && (srl_cnt_q != '0);
      srl_cnt_next = srl_cnt_q;
      if (wr_acc && !load) begin
        srl_cnt_next = srl_cnt_q + CW'(1);
      end else if (load && !wr_acc) begin
        srl_cnt_next = srl_cnt_q - CW'(1);
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        srl_cnt_q   <= '0;
        out_valid_q <= 1'b0;
        out_data_q  <= '0;
      end else begin
        srl_cnt_q <= srl_cnt_next;
        if (load) begin
          out_valid_q <= 1'b1;
          out_data_q  <= srl_dout;
        end else if (rd_acc) begin
          out_valid_q <= 1'b0;
        end
      end
    end

    assign head_valid = out_valid_q;
    assign head_data  = out_data_q;
  end

  assign if_full_n        = full_n_q;
  assign if_almost_full_n = af_n_q;
  assign if_empty_n       = head_valid;
  assign if_dout          = head_data;
  assign count            = count_q;

endmodule

// File: tb/tb_hls_srl_fifo_param.sv
// Scoreboard bench: one direct-output and one registered-output FIFO driven by the same stream.
module tb_hls_srl_fifo_param;
  import hls_fifo_pkg::*;

  localparam int unsigned DW = 8;
  localparam int unsigned D  = 4;
  localparam int unsigned AF = 3;
  localparam int unsigned CW = 3;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          if_write;
  logic          if_read;
  logic [DW-1:0] if_din;
  logic [1:0]    full_n;
  logic [1:0]    af_n;
  logic [1:0]    empty_n;
  logic [DW-1:0] dout0, dout1;
  logic [CW-1:0] cnt0, cnt1;

  int            m_cnt [2];
  bit            m_vis [2];
  logic [DW-1:0] sb0 [$];
  logic [DW-1:0] sb1 [$];
  int            n_cmp = 0;
  int            n_err = 0;
  bit            done  = 1'b0;

  always #5 clk = ~clk;

  hls_srl_fifo_param #(.DATA_WIDTH(DW), .DEPTH(D), .AF_THRESH(AF), .OUTPUT_REG(0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .if_write(if_write), .if_din(if_din),
    .if_full_n(full_n[0]), .if_almost_full_n(af_n[0]), .if_read(if_read),
    .if_dout(dout0), .if_empty_n(empty_n[0]), .count(cnt0));

  hls_srl_fifo_param #(.DATA_WIDTH(DW), .DEPTH(D), .AF_THRESH(AF), .OUTPUT_REG(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .if_write(if_write), .if_din(if_din),
    .if_full_n(full_n[1]), .if_almost_full_n(af_n[1]), .if_read(if_read),
    .if_dout(dout1), .if_empty_n(empty_n[1]), .count(cnt1));

  function automatic int cap_of(input int k);
    return (k == 0) ? 4 : 5;
  endfunction

  // Reference model: occupancy plus a readable flag. A word becomes readable at the edge
  // after its write (direct), or once a word has been held across an edge (registered).
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < 2; k++) begin
        m_cnt[k] <= 0;
        m_vis[k] <= 1'b0;
      end
      sb0.delete();
      sb1.delete();
    end else begin
      for (int k = 0; k < 2; k++) begin
        bit w;
        bit r;
        int n;
        n = m_cnt[k];
        w = if_write && (n != cap_of(k));
        r = if_read && m_vis[k];
        if (w && k == 0) sb0.push_back(if_din);
        if (w && k == 1) sb1.push_back(if_din);
        m_cnt[k] <= n + int'(w) - int'(r);
        m_vis[k] <= (k == 1) ? ((n - int'(r)) > 0) : ((n + int'(w) - int'(r)) > 0);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: flags/count against the model every cycle, popped data on every accepted read.
  initial begin
    logic [DW-1:0] e;
    bit            have;
    int            c;
    int            cov [3];
    occ_state_e    st;
    cov = '{0, 0, 0};
    forever begin
      @(negedge clk or negedge reset_n or posedge done);
      #1;
      if (done) break;
      for (int k = 0; k < 2; k++) begin
        c = (k == 0) ? int'(cnt0) : int'(cnt1);
        chk($sformatf("dut%0d count", k), c, m_cnt[k]);
        chk($sformatf("dut%0d full_n", k), int'(full_n[k]), int'(m_cnt[k] != cap_of(k)));
        chk($sformatf("dut%0d almost_full_n", k), int'(af_n[k]), int'(m_cnt[k] < int'(AF)));
        chk($sformatf("dut%0d empty_n", k), int'(empty_n[k]), int'(m_vis[k]));
        if (reset_n && if_read && empty_n[k]) begin
          have = 1'b0;
          if (k == 0 && sb0.size() > 0) begin e = sb0.pop_front(); have = 1'b1; end
          if (k == 1 && sb1.size() > 0) begin e = sb1.pop_front(); have = 1'b1; end
          if (!have) chk($sformatf("dut%0d read with no expected word", k), 1, 0);
          else chk($sformatf("dut%0d dout", k), (k == 0) ? int'(dout0) : int'(dout1), int'(e));
        end
      end
      st = (m_cnt[0] == 0) ? EMPTY : (m_cnt[0] == cap_of(0)) ? FULL : PARTIAL;
      cov[int'(st)]++;
    end
    chk("dut0 words left", int'(cnt0), sb0.size());
    chk("dut1 words left", int'(cnt1), sb1.size());
    $display("occupancy visits (dut0): empty %0d partial %0d full %0d", cov[0], cov[1], cov[2]);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  task automatic step(input bit w, input logic [DW-1:0] d, input bit r);
    if_write = w;
    if_din   = d;
    if_read  = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [DW-1:0] seq;
    int            wp;
    int            rp;
    reset_n  = 1'b1;
    if_write = 1'b0;
    if_read  = 1'b0;
    if_din   = '0;
    #1 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Fill then drain in order.
    step(1, 8'h11, 0); step(1, 8'h22, 0); step(1, 8'h33, 0); step(1, 8'h44, 0);
    step(0, '0, 0); step(0, '0, 0);
    repeat (6) step(0, '0, 1);

    // Write into a full FIFO alongside a read: the write is dropped, the read proceeds.
    step(1, 8'h11, 0); step(1, 8'h22, 0); step(1, 8'h33, 0); step(1, 8'h44, 0);
    step(0, '0, 0); step(0, '0, 0);
    step(1, 8'h55, 1);
    repeat (7) step(0, '0, 1);

    // Steady stream at occupancy two.
    step(1, 8'h01, 0); step(1, 8'h02, 0); step(0, '0, 0); step(0, '0, 0);
    seq = 8'h03;
    repeat (100) begin
      step(1, seq, 1);
      seq = seq + 8'd1;
    end
    repeat (6) step(0, '0, 1);

    // Asynchronous reset mid-stream, then fresh data.
    step(1, 8'h61, 0); step(1, 8'h62, 0); step(1, 8'h63, 0);
    if_write = 1'b0;
    #2 reset_n = 1'b0;
    @(posedge clk);
    #3 reset_n = 1'b1;
    @(posedge clk);
    #1;
    step(1, 8'h77, 0); step(0, '0, 0); step(0, '0, 0);
    repeat (3) step(0, '0, 1);

    // Randomised traffic in fill-biased, drain-biased and balanced phases.
    for (int ph = 0; ph < 3; ph++) begin
      wp = (ph == 0) ? 70 : (ph == 1) ? 30 : 60;
      rp = (ph == 0) ? 30 : (ph == 1) ? 70 : 60;
      repeat (250) begin
        step(($urandom_range(0, 99) < wp), DW'($urandom), ($urandom_range(0, 99) < rp));
      end
    end

    step(0, '0, 0);
    step(0, '0, 0);
    done = 1'b1;
  end

endmodule
